// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with two combinational read ports,
// one synchronous write port, per-entry pending (scoreboard) bits and a
// multi-cycle clear engine that zeroes one entry per cycle.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 32,
   parameter bit ZERO_REG = 1'b1,
   localparam int ADDR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic              pend1,
   output logic              pend2,
   input  logic              we,
   input  logic [ADDR_W-1:0] wn,
   input  logic [DATA_W-1:0] wd,
   output logic              wr_ready,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_reg,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done
);

   typedef enum logic [0:0] {
      IDLE_S  = 1'b0,
      SWEEP_S = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                done_q, done_d;
   logic [DATA_W-1:0]   file_q [DEPTH];
   logic [DATA_W-1:0]   file_d [DEPTH];
   logic [DEPTH-1:0]    pend_q, pend_d;

   logic                wr_en_s;
   logic                iss_en_s;
   logic                byp1_s;
   logic                byp2_s;
   logic                zero1_s;
   logic                zero2_s;

   assign clr_busy = (state_q == SWEEP_S);
   assign clr_done = done_q;
   assign wr_ready = ~clr_busy;

   // Qualify write/issue requests: blocked during the sweep and, with a hardwired zero entry, dropped for entry 0.
   always_comb begin
      wr_en_s  = we & wr_ready & ~(ZERO_REG & (wn == {ADDR_W{1'b0}}));
      iss_en_s = iss_valid & ~clr_busy & ~(ZERO_REG & (iss_reg == {ADDR_W{1'b0}}));
      zero1_s  = ZERO_REG & (rs == {ADDR_W{1'b0}});
      zero2_s  = ZERO_REG & (rt == {ADDR_W{1'b0}});
   end

`ifdef REGFILE_BYPASS_EN
   assign byp1_s = wr_en_s & (wn == rs);
   assign byp2_s = wr_en_s & (wn == rt);
`else
   assign byp1_s = 1'b0;
   assign byp2_s = 1'b0;
`endif

   // Read port 1: hardwired zero first, then optional forwarding, else stored contents.
   always_comb begin
      rd1   = file_q[rs];
      pend1 = pend_q[rs];
      if (zero1_s) begin
         rd1   = {DATA_W{1'b0}};
         pend1 = 1'b0;
      end else if (byp1_s) begin
         rd1   = wd;
         pend1 = 1'b0;
      end else begin
         rd1   = file_q[rs];
         pend1 = pend_q[rs];
      end
   end

   // Read port 2: same selection as port 1, driven by rt.
   always_comb begin
      rd2   = file_q[rt];
      pend2 = pend_q[rt];
      if (zero2_s) begin
         rd2   = {DATA_W{1'b0}};
         pend2 = 1'b0;
      end else if (byp2_s) begin
         rd2   = wd;
         pend2 = 1'b0;
      end else begin
         rd2   = file_q[rt];
         pend2 = pend_q[rt];
      end
   end

   // Next-state for clear FSM, file contents and scoreboard; issue is applied after write so it wins.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      file_d  = file_q;
      pend_d  = pend_q;
      case (state_q)
         IDLE_S: begin
            if (clr_req) begin
               state_d = SWEEP_S;
               cnt_d   = {ADDR_W{1'b0}};
            end else begin
               state_d = IDLE_S;
            end
         end
         SWEEP_S: begin
            file_d[cnt_q] = {DATA_W{1'b0}};
            pend_d[cnt_q] = 1'b0;
            cnt_d         = cnt_q + ADDR_W'(1);
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
               state_d = IDLE_S;
               done_d  = 1'b1;
            end else begin
               state_d = SWEEP_S;
            end
         end
         default: begin
            state_d = IDLE_S;
            cnt_d   = {ADDR_W{1'b0}};
         end
      endcase
      if (wr_en_s) begin
         file_d[wn] = wd;
         pend_d[wn] = 1'b0;
      end else begin
         pend_d = pend_d;
      end
      if (iss_en_s) begin
         pend_d[iss_reg] = 1'b1;
      end else begin
         pend_d = pend_d;
      end
   end

   // State register with synchronous active-low reset that overrides every other input.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE_S;
         cnt_q   <= {ADDR_W{1'b0}};
         done_q  <= 1'b0;
         pend_q  <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            file_q[i] <= {DATA_W{1'b0}};
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         pend_q  <= pend_d;
         file_q  <= file_d;
      end
   end

endmodule
